pneumatic_valve_seq: RTL and testbench
======================================

Name: pneumatic_valve_seq

Overview:
- Next-generation pneumatic valve driver. Replaces the fixed 3-valve, all-at-once switching with N parametrised valve channels.
- Takes one command bit from the Raspberry Pi (signalrasp). The command is asynchronous, so the block synchronises it.
- Opens the masked valves one after another with a fixed stagger, to limit the compressor inrush.
- Enforces a minimum on-time, closes the valves in reverse order, and forces all valves shut with a latched fault after a maximum on-time.
- Sits between the Pi GPIO input and the valve driver pins.

Parameters:
N_CH, 3, number of valve channels (1..16)
STAGGER_CYC, 50000, clock cycles between successive channel open/close events (>=1)
HOLD_MIN_CYC, 500000, minimum cycles valves stay energised after the first open
TIMEOUT_CYC, 50000000, maximum energised cycles before forced shutdown (> HOLD_MIN_CYC)
SYNC_STAGES, 2, flip-flop stages in the signalrasp synchroniser (>=2)

Ports:
clk  in  1  system clock, single clock domain
reset  in  1  synchronous, active-low reset (asserted when 0, sampled on rising clk)
signalrasp  in  1  asynchronous actuate command from Raspberry Pi; 1 = actuate
ch_mask  in  N_CH  channels taking part in the next actuation
fault_clr  in  1  clears a latched fault (level-sensitive)
valve  out  N_CH  valve drive; bit i = 1 energises channel i
busy  out  1  1 in OPENING, HOLD or CLOSING
fault  out  1  timeout fault latched

Behaviour:
- Reset (reset=0 at a rising edge):
  - valve=0, busy=0, fault=0, state=IDLE.
  - Synchroniser flops, timers, channel index and latched mask are all cleared.
  - Reset overrides everything, including mid-sequence operation and FAULT.
- All outputs are registered.
- cmd_s is signalrasp after SYNC_STAGES flops.
- Latency: signalrasp first sampled high at edge k gives valve bit set after edge k+SYNC_STAGES.
- State IDLE:
  - valve=0.
  - If cmd_s=1 and ch_mask!=0: latch ch_mask, set valve bit of the lowest masked channel, clear both timers, go to OPENING.
  - If cmd_s=1 and ch_mask=0: stay IDLE.
- State OPENING:
  - Every STAGGER_CYC cycles after the previous open, set the next higher masked bit.
  - When the highest masked bit is set, go to HOLD.
  - The latched mask is not re-sampled during a sequence.
- State HOLD: all latched channels on.
- Leaving OPENING or HOLD:
  - on_timer counts cycles since the first open and saturates at TIMEOUT_CYC.
  - When cmd_s=0 and on_timer>=HOLD_MIN_CYC, go to CLOSING.
  - On that same edge, clear the highest currently-set valve bit.
  - If cmd_s drops before HOLD_MIN_CYC, keep the current valves and continue the opening sequence. The close starts the first cycle both conditions hold.
- State CLOSING:
  - Every STAGGER_CYC cycles, clear the next lower set bit.
  - When valve==0, go to IDLE.
  - cmd_s rising during CLOSING is ignored. The block completes the close, enters IDLE, and re-opens on the following edge if cmd_s is still 1.
- Timeout:
  - Applies in OPENING or HOLD when on_timer reaches TIMEOUT_CYC.
  - On that edge: valve=0 (all at once, no stagger), fault=1, go to FAULT.
  - Timeout has priority over stagger and close events on the same edge.
- State FAULT:
  - valve=0, fault=1, busy=0.
  - Exit to IDLE (fault=0) only when fault_clr=1 and cmd_s=0 on the same edge.
  - fault_clr with cmd_s=1 has no effect.
- Timers:
  - Width is $clog2 of the larger of the compared parameters plus 1.
  - The stagger timer resets on every open/close event.
- Single-channel mask:
  - OPENING goes to HOLD on the edge after the first open.
  - CLOSING goes to IDLE after one clear.

Decomposition:
- Shared package pneumatic_pkg holds:
  - the state_t enum (IDLE, OPENING, HOLD, CLOSING, FAULT);
  - the default timing constants.
- One sub-module, bit_sync: an SYNC_STAGES-deep synchroniser with synchronous active-low reset, reusable for other Pi inputs.

Test Plan (N_CH=3, STAGGER_CYC=4, HOLD_MIN_CYC=20, TIMEOUT_CYC=100, SYNC_STAGES=2):
1. Open sequence: release reset, mask=111, signalrasp=1 at edge 0 -> valve=001 after edge 2, 011 after edge 6, 111 after edge 10, busy=1.
2. Minimum hold and close: from test 1, drop signalrasp at edge 12 -> valve stays 111 until on_timer=20 (edge 22), then 011, 001, 000 at 4-cycle spacing; busy=0 with 000.
3. Sparse mask: mask=101, signalrasp=1 -> 001, then 101 four cycles later; bit1 stays 0; close order is 001 then 000.
4. Timeout: hold signalrasp=1 -> valve=000 and fault=1 at on_timer=100.
   - fault_clr=1 with signalrasp=1 -> fault stays 1.
   - signalrasp=0 plus fault_clr=1 -> IDLE, fault=0.
5. Mid-sequence reset: reset=0 while valve=011 -> valve=000, busy=0, fault=0 next edge; no re-open until reset=1 and SYNC_STAGES edges elapse.
6. Empty mask and re-trigger: mask=000, signalrasp=1 -> valve stays 000, busy=0. Raise signalrasp during CLOSING -> close completes to 000, then reopens starting at 001.

Source files
------------

// File: rtl/pneumatic_pkg.sv
// Shared state encoding and default timing for the pneumatic valve sequencer.
// Pure definitions: no latency, no backpressure.
package pneumatic_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        OPENING = 3'd1,
        HOLD    = 3'd2,
        CLOSING = 3'd3,
        FAULT   = 3'd4
    } state_t;

    localparam int DEF_N_CH         = 3;
    localparam int DEF_STAGGER_CYC  = 50000;
    localparam int DEF_HOLD_MIN_CYC = 500000;
    localparam int DEF_TIMEOUT_CYC  = 50000000;
    localparam int DEF_SYNC_STAGES  = 2;

endpackage

// File: rtl/pneumatic_valve_seq_bit_sync.sv
// Multi-flop synchroniser for an asynchronous single-bit input.
// Latency STAGES cycles; no backpressure.
module bit_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/pneumatic_valve_seq.sv
// Staggered open / reverse close valve driver with minimum hold and timeout fault.
// First valve drives SYNC_STAGES edges after signalrasp is sampled high; no backpressure.
module pneumatic_valve_seq
    import pneumatic_pkg::*;
#(
    parameter int N_CH         = DEF_N_CH,
    parameter int STAGGER_CYC  = DEF_STAGGER_CYC,
    parameter int HOLD_MIN_CYC = DEF_HOLD_MIN_CYC,
    parameter int TIMEOUT_CYC  = DEF_TIMEOUT_CYC,
    parameter int SYNC_STAGES  = DEF_SYNC_STAGES
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            signalrasp,
    input  logic [N_CH-1:0] ch_mask,
    input  logic            fault_clr,
    output logic [N_CH-1:0] valve,
    output logic            busy,
    output logic            fault
);

    localparam int TMAX_A = (TIMEOUT_CYC > HOLD_MIN_CYC) ? TIMEOUT_CYC : HOLD_MIN_CYC;
    localparam int TMAX   = (TMAX_A > STAGGER_CYC) ? TMAX_A : STAGGER_CYC;
    localparam int TW     = $clog2(TMAX) + 1;

    logic            cmd_s;
    state_t          state;
    logic [N_CH-1:0] mask_q;
    logic [TW-1:0]   on_timer;
    logic [TW-1:0]   stag_timer;
    logic [TW-1:0]   on_next;
    logic [TW-1:0]   stag_next;
    logic            stag_evt;
    logic            hold_ok;
    logic            tmo;
    logic [N_CH-1:0] first_bit;
    logic [N_CH-1:0] open_bit;
    logic [N_CH-1:0] close_bit;
    logic [N_CH-1:0] valve_cls;

    bit_sync #(
        .STAGES (SYNC_STAGES)
    ) u_cmd_sync (
        .clk   (clk),
        .reset (reset),
        .d     (signalrasp),
        .q     (cmd_s)
    );

    // Timer compares use the post-increment value so events land exactly N cycles after their reference edge.
    always_comb begin
        on_next   = (on_timer >= TW'(TIMEOUT_CYC)) ? on_timer : on_timer + 1'b1;
        stag_next = (stag_timer >= TW'(STAGGER_CYC)) ? stag_timer : stag_timer + 1'b1;
        stag_evt  = (stag_next >= TW'(STAGGER_CYC));
        hold_ok   = (on_next >= TW'(HOLD_MIN_CYC));
        tmo       = (on_next >= TW'(TIMEOUT_CYC));
    end

    // Lowest requested bit, next masked bit to open, highest energised bit to close.
    always_comb begin
        first_bit = '0;
        open_bit  = '0;
        close_bit = '0;
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (ch_mask[i]) begin
                first_bit    = '0;
                first_bit[i] = 1'b1;
            end
            if (mask_q[i] && !valve[i]) begin
                open_bit    = '0;
                open_bit[i] = 1'b1;
            end
        end
        for (int i = 0; i < N_CH; i++) begin
            if (valve[i]) begin
                close_bit    = '0;
                close_bit[i] = 1'b1;
            end
        end
        valve_cls = valve & ~close_bit;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            valve      <= '0;
            busy       <= 1'b0;
            fault      <= 1'b0;
            mask_q     <= '0;
            on_timer   <= '0;
            stag_timer <= '0;
        end else begin
            case (state)
                IDLE: begin
                    valve <= '0;
                    busy  <= 1'b0;
                    fault <= 1'b0;
                    if (cmd_s && (ch_mask != '0)) begin
                        mask_q     <= ch_mask;
                        valve      <= first_bit;
                        on_timer   <= '0;
                        stag_timer <= '0;
                        busy       <= 1'b1;
                        state      <= OPENING;
                    end
                end
                OPENING, HOLD: begin
                    on_timer   <= on_next;
                    stag_timer <= stag_next;
                    if (tmo) begin
                        valve <= '0;
                        fault <= 1'b1;
                        busy  <= 1'b0;
                        state <= FAULT;
                    end else if (!cmd_s && hold_ok) begin
                        valve      <= valve_cls;
                        stag_timer <= '0;
                        if (valve_cls == '0) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end else begin
                            state <= CLOSING;
                        end
                    end else if (state == OPENING) begin
                        if (valve == mask_q) begin
                            state <= HOLD;
                        end else if (stag_evt) begin
                            valve      <= valve | open_bit;
                            stag_timer <= '0;
                        end
                    end
                end
                CLOSING: begin
                    stag_timer <= stag_next;
                    if (stag_evt) begin
                        valve      <= valve_cls;
                        stag_timer <= '0;
                        if (valve_cls == '0) begin
                            busy  <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                FAULT: begin
                    valve <= '0;
                    busy  <= 1'b0;
                    fault <= 1'b1;
                    if (fault_clr && !cmd_s) begin
                        fault <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    valve <= '0;
                    busy  <= 1'b0;
                    fault <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pneumatic_valve_seq.sv
// Scoreboard bench: a timestamp-based episode model predicts every output change.
// A separate monitor pops and compares whenever the DUT outputs change.
module tb_pneumatic_valve_seq;

    localparam int N_CH = 3;
    localparam int S    = 4;
    localparam int HOLD = 20;
    localparam int TO   = 100;
    localparam int SYNC = 2;
    localparam int MAXL = 400;
    localparam int BIG  = 1 << 30;

    typedef struct {
        int              cyc;
        logic [N_CH-1:0] v;
        logic            b;
        logic            f;
    } exp_t;

    logic            clk;
    logic            reset;
    logic            signalrasp;
    logic [N_CH-1:0] ch_mask;
    logic            fault_clr;
    logic [N_CH-1:0] valve;
    logic            busy;
    logic            fault;

    pneumatic_valve_seq #(
        .N_CH         (N_CH),
        .STAGGER_CYC  (S),
        .HOLD_MIN_CYC (HOLD),
        .TIMEOUT_CYC  (TO),
        .SYNC_STAGES  (SYNC)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .signalrasp (signalrasp),
        .ch_mask    (ch_mask),
        .fault_clr  (fault_clr),
        .valve      (valve),
        .busy       (busy),
        .fault      (fault)
    );

    int   vectors = 0;
    int   miscompares = 0;
    int   cyc = 0;
    logic armed = 1'b0;
    logic [N_CH+1:0] last_seen;
    logic [N_CH+1:0] mprev;
    exp_t q[$];

    // Stimulus per scenario edge and the expected outputs after that edge.
    logic            sig  [MAXL];
    logic            rstv [MAXL];
    logic            clr  [MAXL];
    logic [N_CH-1:0] msk  [MAXL];
    logic [N_CH-1:0] ev   [MAXL];
    logic            eb   [MAXL];
    logic            ef   [MAXL];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // The command seen at edge t is signalrasp from SYNC edges earlier, unless a reset flushed the synchroniser.
    function automatic logic cmd_at(input int t);
        if (t < SYNC) return 1'b0;
        for (int k = 1; k <= SYNC; k++) if (rstv[t-k]) return 1'b0;
        return sig[t-SYNC];
    endfunction

    task automatic model(input int len);
        int e, t0, n, opened, tc, tt, tclr, busy_end, fault_s, tend, last, t;
        int ch[$];
        int on_t[N_CH];
        int off_t[N_CH];
        logic brk;
        e = 0;
        while (e < len) begin
            if (rstv[e] || !cmd_at(e) || msk[e] == '0) begin
                ev[e] = '0; eb[e] = 1'b0; ef[e] = 1'b0;
                e++;
            end else begin
                t0 = e;
                ch.delete();
                for (int i = 0; i < N_CH; i++) if (msk[e][i]) ch.push_back(i);
                n = ch.size();
                for (int j = 0; j < n; j++) begin
                    on_t[j]  = t0 + j * S;
                    off_t[j] = BIG;
                end
                tc = -1;
                for (int u = t0 + HOLD; u < t0 + TO && u < len; u++) begin
                    if (!cmd_at(u)) begin tc = u; break; end
                end
                tt = t0 + TO;
                tclr = BIG;
                if (tc >= 0) begin
                    opened = 0;
                    for (int j = 0; j < n; j++) if (on_t[j] < tc) opened++;
                    for (int j = 0; j < n; j++) begin
                        if (j >= opened) on_t[j] = BIG;
                        else off_t[j] = tc + (opened - 1 - j) * S;
                    end
                    tend = tc + (opened - 1) * S;
                    busy_end = tend;
                    fault_s = BIG;
                end else begin
                    for (int j = 0; j < n; j++) begin
                        if (on_t[j] >= tt) on_t[j] = BIG;
                        off_t[j] = tt;
                    end
                    busy_end = tt;
                    fault_s = tt;
                    for (int u = tt + 1; u < len; u++) begin
                        if (clr[u] && !cmd_at(u)) begin tclr = u; break; end
                    end
                    tend = tclr;
                end
                last = (tend < len - 1) ? tend : len - 1;
                brk = 1'b0;
                t = t0;
                while (t <= last && !brk) begin
                    if (t > t0 && rstv[t]) begin
                        brk = 1'b1;
                    end else begin
                        ev[t] = '0;
                        for (int j = 0; j < n; j++)
                            if (on_t[j] <= t && off_t[j] > t) ev[t][ch[j]] = 1'b1;
                        eb[t] = (t < busy_end);
                        ef[t] = (t >= fault_s) && (t < tclr);
                        t++;
                    end
                end
                e = t;
            end
        end
    endtask

    task automatic clear_scn(input int len, input logic [N_CH-1:0] m);
        for (int e = 0; e < len; e++) begin
            sig[e] = 1'b0; clr[e] = 1'b0; msk[e] = m;
            rstv[e] = (e < 2);
        end
    endtask

    task automatic set_range(input int a, input int b, input int which, input logic val);
        for (int e = a; e <= b; e++) begin
            if (which == 0) sig[e] = val;
            else if (which == 1) clr[e] = val;
            else rstv[e] = val;
        end
    endtask

    task automatic run_scn(input int len);
        int base;
        exp_t x;
        logic [N_CH+1:0] cur;
        base = cyc + 1;
        model(len);
        for (int e = 0; e < len; e++) begin
            cur = {ev[e], eb[e], ef[e]};
            if (cur !== mprev) begin
                x.cyc = base + e; x.v = ev[e]; x.b = eb[e]; x.f = ef[e];
                q.push_back(x);
                mprev = cur;
            end
        end
        for (int e = 0; e < len; e++) begin
            reset      = ~rstv[e];
            signalrasp = sig[e];
            ch_mask    = msk[e];
            fault_clr  = clr[e];
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        exp_t x;
        logic [N_CH+1:0] cur;
        forever begin
            @(negedge clk);
            if (armed) begin
                cur = {valve, busy, fault};
                if (cur !== last_seen) begin
                    last_seen = cur;
                    vectors++;
                    if (q.size() == 0) begin
                        miscompares++;
                        $display("FAIL unexpected_change cyc=%0d got valve=%b busy=%b fault=%b, required no change",
                                 cyc, valve, busy, fault);
                    end else begin
                        x = q.pop_front();
                        if (x.cyc != cyc || x.v !== valve || x.b !== busy || x.f !== fault) begin
                            miscompares++;
                            $display("FAIL output_step got valve=%b busy=%b fault=%b @cyc %0d, required valve=%b busy=%b fault=%b @cyc %0d",
                                     valve, busy, fault, cyc, x.v, x.b, x.f, x.cyc);
                        end
                    end
                end
            end
        end
    end

    initial begin
        int len;
        logic val;
        int run;
        reset = 1'b0; signalrasp = 1'b0; ch_mask = '0; fault_clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        vectors++;
        if ({valve, busy, fault} !== '0) begin
            miscompares++;
            $display("FAIL reset_state got valve=%b busy=%b fault=%b, required all 0", valve, busy, fault);
        end
        last_seen = '0;
        mprev = '0;
        armed = 1'b1;

        // Open sequence, minimum hold, staggered reverse close.
        clear_scn(60, 3'b111); set_range(2, 13, 0, 1'b1); run_scn(60);
        // Sparse mask.
        clear_scn(70, 3'b101); set_range(2, 30, 0, 1'b1); run_scn(70);
        // Timeout, ignored clear while commanded, then clear.
        clear_scn(160, 3'b111); set_range(2, 130, 0, 1'b1);
        set_range(110, 120, 1, 1'b1); set_range(140, 141, 1, 1'b1); run_scn(160);
        // Mid-sequence reset while 011.
        clear_scn(40, 3'b111); set_range(2, 39, 0, 1'b1); set_range(10, 12, 2, 1'b1); run_scn(40);
        // Empty mask, then re-trigger during closing.
        clear_scn(80, 3'b000); set_range(2, 24, 0, 1'b1); set_range(46, 79, 0, 1'b1);
        for (int e = 21; e < 80; e++) msk[e] = 3'b111;
        run_scn(80);

        for (int s = 0; s < 12; s++) begin
            len = 300;
            clear_scn(len, N_CH'($urandom_range(0, 7)));
            val = 1'b0;
            run = 0;
            for (int e = 2; e < len; e++) begin
                if (run == 0) begin
                    val = ~val;
                    run = $urandom_range(1, 70);
                end
                run--;
                sig[e] = val;
                if ($urandom_range(0, 39) == 0) msk[e] = N_CH'($urandom_range(0, 7));
                else msk[e] = msk[e-1];
                clr[e]  = ($urandom_range(0, 9) == 0);
                rstv[e] = ($urandom_range(0, 299) == 0);
            end
            run_scn(len);
        end

        repeat (4) @(posedge clk);
        #1;
        vectors++;
        if (q.size() != 0) begin
            miscompares++;
            $display("FAIL pending_expect got %0d unmatched entries, required 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
